uart_cmd_parser: RTL and testbench



---
 rtl/uart_cmd_pkg.sv | 47 ++++
 rtl/uart_cmd_if.sv | 14 +
 rtl/uart_resp_tx.sv | 89 ++++++++
 rtl/uart_cmd_parser.sv | 156 +++++++++++++++
 tb/tb_uart_cmd_parser.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared types, ASCII constants and hex helpers for the UART command parser.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_L_HI,
    ST_L_LO,
    ST_EOL_L,
    ST_EOL_R,
    ST_DISCARD,
    ST_RESP
  } state_t;

  typedef enum logic [1:0] {
    RESP_OK,
    RESP_ERR,
    RESP_RB
  } resp_kind_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] nib;
  } hex_nib_t;

  localparam logic [7:0] CHAR_L = 8'h4C;
  localparam logic [7:0] CHAR_R = 8'h52;
  localparam logic [7:0] CHAR_K = 8'h4B;
  localparam logic [7:0] CHAR_Q = 8'h3F;
  localparam logic [7:0] CR     = 8'h0D;
  localparam logic [7:0] LF     = 8'h0A;

  function automatic hex_nib_t hex_to_nib(input logic [7:0] c);
    hex_nib_t r;
    r.valid = 1'b1;
    r.nib   = 4'h0;
    if (c >= 8'h30 && c <= 8'h39)      r.nib = 4'(c - 8'h30);
    else if (c >= 8'h41 && c <= 8'h46) r.nib = 4'(c - 8'h37);
    else if (c >= 8'h61 && c <= 8'h66) r.nib = 4'(c - 8'h57);
    else                               r.valid = 1'b0;
    return r;
  endfunction

  function automatic logic [7:0] nib_to_hex(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

endpackage

// File: rtl/uart_cmd_if.sv
// Byte streams between the UART receiver/transmitter and the command parser.
// rx: rx_data is meaningful only in the cycle rx_valid=1; there is no back-pressure.
// tx: a byte moves when tx_valid && tx_ready at a clock edge; once tx_valid is
//     raised, tx_valid and tx_data hold steady until that handshake occurs.
interface uart_cmd_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output rx_data, rx_valid, tx_ready, input tx_data, tx_valid);
  modport slave  (input rx_data, rx_valid, tx_ready, output tx_data, tx_valid);
endinterface

// File: rtl/uart_resp_tx.sv
// Sequences one 3- or 4-byte ASCII response over the tx valid/ready handshake.
module uart_resp_tx
  import uart_cmd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  resp_kind_t kind,
  input  logic [7:0] value,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       done
);

  logic       valid_q, valid_d;
  logic [7:0] data_q, data_d;
  logic [1:0] idx_q, idx_d;
  resp_kind_t kind_q, kind_d;
  logic [7:0] val_q, val_d;
  logic       last, hs;

  function automatic logic [7:0] byte_at(input resp_kind_t k, input logic [7:0] v,
                                         input logic [1:0] i);
    logic [7:0] b;
    b = LF;
    if (k == RESP_RB) begin
      case (i)
        2'd0:    b = nib_to_hex(v[7:4]);
        2'd1:    b = nib_to_hex(v[3:0]);
        2'd2:    b = CR;
        default: b = LF;
      endcase
    end else begin
      case (i)
        2'd0:    b = (k == RESP_OK) ? CHAR_K : CHAR_Q;
        2'd1:    b = CR;
        default: b = LF;
      endcase
    end
    return b;
  endfunction

  assign last = (kind_q == RESP_RB) ? (idx_q == 2'd3) : (idx_q == 2'd2);
  assign hs   = valid_q && tx_ready;
  assign done = hs && last;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    idx_d   = idx_q;
    kind_d  = kind_q;
    val_d   = val_q;
    if (load) begin
      valid_d = 1'b1;
      idx_d   = 2'd0;
      kind_d  = kind;
      val_d   = value;
      data_d  = byte_at(kind, value, 2'd0);
    end else if (hs) begin
      if (last) begin
        valid_d = 1'b0;
      end else begin
        idx_d  = idx_q + 2'd1;
        data_d = byte_at(kind_q, val_q, idx_q + 2'd1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= 8'h00;
      idx_q   <= 2'd0;
      kind_q  <= RESP_OK;
      val_q   <= 8'h00;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      kind_q  <= kind_d;
      val_q   <= val_d;
    end
  end

  assign tx_data  = data_q;
  assign tx_valid = valid_q;

endmodule

// File: rtl/uart_cmd_parser.sv
// ASCII command parser owning the LED register: "Lhh<EOL>" sets, "R<EOL>" reads back.
// Optional partial-command timeout is enabled by defining UART_CMD_TIMEOUT_EN.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int LED_WIDTH      = 6,
  parameter int TIMEOUT_CYCLES = 2700000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  uart_cmd_if.slave            bus,
  output logic [LED_WIDTH-1:0] led_value,
  output logic                 busy,
  output logic                 rx_drop,
  output logic                 cmd_timeout
);

  if (LED_WIDTH < 1 || LED_WIDTH > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("uart_cmd_parser: parameter out of range");
  end

  state_t               state_q, state_d;
  logic [3:0]           hi_q, hi_d, lo_q, lo_d;
  logic [LED_WIDTH-1:0] led_q, led_d;
  logic                 load_q, load_d;
  resp_kind_t           kind_q, kind_d;
  logic [7:0]           val_q, val_d;
  logic [7:0]           led_byte, led_ext;
  logic                 resp_done, eol, is_l, is_r;
  hex_nib_t             hn;

  assign hn       = hex_to_nib(bus.rx_data);
  assign eol      = (bus.rx_data == CR) || (bus.rx_data == LF);
  assign is_l     = (bus.rx_data | 8'h20) == (CHAR_L | 8'h20);
  assign is_r     = (bus.rx_data | 8'h20) == (CHAR_R | 8'h20);
  assign led_byte = {hi_q, lo_q};
  assign led_ext  = 8'(led_q);

`ifdef UART_CMD_TIMEOUT_EN
  localparam logic [23:0] TO_LAST = 24'(TIMEOUT_CYCLES - 1);
  logic [23:0] cnt_q, cnt_d;
  logic        to_q, to_d;
  logic        partial;

  assign partial = (state_q != ST_IDLE) && (state_q != ST_RESP);
`endif

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    led_d   = led_q;
    load_d  = 1'b0;
    kind_d  = kind_q;
    val_d   = val_q;
    if (bus.rx_valid && state_q != ST_RESP) begin
      // Default for any unexpected byte mid-command; overridden below.
      state_d = ST_DISCARD;
      case (state_q)
        ST_IDLE: begin
          if (is_l)      state_d = ST_L_HI;
          else if (is_r) state_d = ST_EOL_R;
          else if (eol)  state_d = ST_IDLE;
        end
        ST_L_HI: begin
          if (hn.valid) begin
            hi_d    = hn.nib;
            state_d = ST_L_LO;
          end else if (eol) begin
            state_d = ST_RESP; load_d = 1'b1; kind_d = RESP_ERR;
          end
        end
        ST_L_LO: begin
          if (hn.valid) begin
            lo_d    = hn.nib;
            state_d = ST_EOL_L;
          end else if (eol) begin
            state_d = ST_RESP; load_d = 1'b1; kind_d = RESP_ERR;
          end
        end
        ST_EOL_L: if (eol) begin
          led_d   = led_byte[LED_WIDTH-1:0];
          state_d = ST_RESP; load_d = 1'b1; kind_d = RESP_OK;
        end
        ST_EOL_R: if (eol) begin
          val_d   = led_ext;
          state_d = ST_RESP; load_d = 1'b1; kind_d = RESP_RB;
        end
        default: if (eol) begin
          state_d = ST_RESP; load_d = 1'b1; kind_d = RESP_ERR;
        end
      endcase
    end else if (state_q == ST_RESP && resp_done) begin
      state_d = ST_IDLE;
    end
`ifdef UART_CMD_TIMEOUT_EN
    to_d  = 1'b0;
    cnt_d = (bus.rx_valid || !partial) ? 24'd0 : cnt_q + 24'd1;
    if (partial && !bus.rx_valid && cnt_q == TO_LAST) begin
      state_d = ST_IDLE;
      to_d    = 1'b1;
      cnt_d   = 24'd0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      hi_q    <= 4'h0;
      lo_q    <= 4'h0;
      led_q   <= '0;
      load_q  <= 1'b0;
      kind_q  <= RESP_OK;
      val_q   <= 8'h00;
`ifdef UART_CMD_TIMEOUT_EN
      cnt_q   <= 24'd0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      led_q   <= led_d;
      load_q  <= load_d;
      kind_q  <= kind_d;
      val_q   <= val_d;
`ifdef UART_CMD_TIMEOUT_EN
      cnt_q   <= cnt_d;
      to_q    <= to_d;
`endif
    end
  end

  uart_resp_tx u_resp_tx (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_q),
    .kind     (kind_q),
    .value    (val_q),
    .tx_data  (bus.tx_data),
    .tx_valid (bus.tx_valid),
    .tx_ready (bus.tx_ready),
    .done     (resp_done)
  );

  assign led_value = led_q;
  assign busy      = (state_q == ST_RESP);
  assign rx_drop   = bus.rx_valid && (state_q == ST_RESP);
`ifdef UART_CMD_TIMEOUT_EN
  assign cmd_timeout = to_q;
`else
  assign cmd_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboarded bench for uart_cmd_parser with a line-based reference model.
`timescale 1ns/1ps
module tb_uart_cmd_parser;
  localparam int LW = 6;
`ifdef UART_CMD_TIMEOUT_EN
  localparam int TO = 100;
`else
  localparam int TO = 2700000;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_cmd_if bus();
  logic [LW-1:0] led_value;
  logic busy, rx_drop, cmd_timeout;

  uart_cmd_parser #(.LED_WIDTH(LW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .led_value(led_value),
    .busy(busy), .rx_drop(rx_drop), .cmd_timeout(cmd_timeout)
  );

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] line_q[$];
  logic [LW-1:0] led_m = '0;
  int ready_mode = 0;
  int stall_cnt = 0;
  int timeout_pulses = 0;
  int drop_pulses = 0;
  int tx_valid_cycles = 0;
  logic prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit m_is_hex(input logic [7:0] c);
    return (c >= "0" && c <= "9") || (c >= "A" && c <= "F") || (c >= "a" && c <= "f");
  endfunction

  function automatic int m_hex_val(input logic [7:0] c);
    if (c >= "0" && c <= "9") return int'(c) - 48;
    if (c >= "A" && c <= "F") return int'(c) - 55;
    return int'(c) - 87;
  endfunction

  function automatic logic [7:0] m_hex_char(input int n);
    return (n < 10) ? 8'(48 + n) : 8'(55 + n);
  endfunction

  function automatic void model_feed(input logic [7:0] c);
    int n;
    int v;
    if (c != 8'h0D && c != 8'h0A) begin
      line_q.push_back(c);
      return;
    end
    n = line_q.size();
    if (n == 0) return;
    if (n == 3 && (line_q[0] == "L" || line_q[0] == "l") && m_is_hex(line_q[1]) && m_is_hex(line_q[2])) begin
      v = m_hex_val(line_q[1]) * 16 + m_hex_val(line_q[2]);
      led_m = LW'(v % (1 << LW));
      exp_q.push_back("K"); exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
    end else if (n == 1 && (line_q[0] == "R" || line_q[0] == "r")) begin
      v = int'(led_m);
      exp_q.push_back(m_hex_char(v / 16)); exp_q.push_back(m_hex_char(v % 16));
      exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
    end else begin
      exp_q.push_back("?"); exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
    end
    line_q.delete();
  endfunction

  // ---------------- drivers ----------------
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    model_feed(b);
    repeat ($urandom_range(0, 2)) @(posedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || busy || bus.tx_valid) && n < 3000) begin
      @(posedge clk); n++;
    end
    check("resp_done_in_time", 32'(n < 3000), 32'd1);
    @(negedge clk);
    check("busy_after_resp", 32'(busy), 32'd0);
    check("led_value", 32'(led_value), 32'(led_m));
  endtask

  task automatic wait_tx_valid();
    int n = 0;
    while (!bus.tx_valid && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check("tx_valid_seen", 32'(bus.tx_valid), 32'd1);
  endtask

  function automatic logic [7:0] rand_hex();
    int n = $urandom_range(0, 15);
    logic [7:0] c = m_hex_char(n);
    if (n >= 10 && $urandom_range(0, 1) == 1) c = c | 8'h20;
    return c;
  endfunction

  function automatic logic [7:0] rand_eol();
    return ($urandom_range(0, 1) == 1) ? 8'h0D : 8'h0A;
  endfunction

  task automatic send_rand_cmd();
    logic [7:0] q[$];
    int k = $urandom_range(0, 5);
    case (k)
      0, 1: begin
        q.push_back($urandom_range(0, 1) ? "L" : "l");
        q.push_back(rand_hex()); q.push_back(rand_hex());
      end
      2: q.push_back($urandom_range(0, 1) ? "R" : "r");
      3: repeat ($urandom_range(1, 5)) q.push_back(8'($urandom_range(32, 126)));
      4: begin
        q.push_back("L");
        if ($urandom_range(0, 1) == 1) q.push_back(rand_hex());
      end
      default: begin
        q.push_back("L"); q.push_back(rand_hex()); q.push_back(rand_hex());
        q.push_back(8'($urandom_range(32, 126)));
      end
    endcase
    q.push_back(rand_eol());
    foreach (q[i]) send_byte(q[i]);
  endtask

  // ---------------- tx_ready generator ----------------
  initial begin
    bus.tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: bus.tx_ready = 1'b1;
        1: bus.tx_ready = ($urandom_range(0, 1) == 1);
        default: begin
          if (bus.tx_ready) stall_cnt = 0;
          else if (bus.tx_valid) stall_cnt++;
          bus.tx_ready = (stall_cnt >= 5);
        end
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (cmd_timeout) timeout_pulses++;
    if (rx_drop) drop_pulses++;
    if (bus.tx_valid) tx_valid_cycles++;
    if (rst_n) begin
      if (prev_hold) check("tx_stable_while_stalled", {23'd0, bus.tx_valid, bus.tx_data}, {23'd0, 1'b1, prev_data});
      if (bus.tx_valid) check("busy_during_tx", 32'(busy), 32'd1);
      if (bus.tx_valid && bus.tx_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL tx_unexpected_byte: got %0h want none at %0t", bus.tx_data, $time);
        end else begin
          check("tx_byte", 32'(bus.tx_data), 32'(exp_q.pop_front()));
        end
      end
    end
    prev_hold = rst_n && bus.tx_valid && !bus.tx_ready;
    prev_data = bus.tx_data;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int base;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_led", 32'(led_value), 32'd0);
    check("reset_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("reset_tx_data", 32'(bus.tx_data), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_rx_drop", 32'(rx_drop), 32'd0);
    check("reset_cmd_timeout", 32'(cmd_timeout), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    ready_mode = 0;
    send_str("L2A\r");
    wait_idle();
    check("led_after_L2A", 32'(led_value), 32'h2A);

    ready_mode = 2;
    send_str("r\n");
    wait_idle();
    ready_mode = 0;

    send_str("LZ9\r");
    wait_idle();
    send_str("L\r");
    wait_idle();

    base = tx_valid_cycles;
    send_str("\r\n\r");
    repeat (20) @(posedge clk);
    check("blank_lines_no_tx", tx_valid_cycles - base, 0);

    ready_mode = 2;
    send_str("R\r");
    wait_tx_valid();
    base = drop_pulses;
    @(posedge clk); #1;
    bus.rx_valid = 1'b1; bus.rx_data = 8'h41;
    @(negedge clk);
    check("rx_drop_pulse", 32'(rx_drop), 32'd1);
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    @(negedge clk);
    check("rx_drop_one_cycle", 32'(rx_drop), 32'd0);
    wait_idle();
    check("rx_drop_count", drop_pulses - base, 1);
    ready_mode = 0;
    send_str("R\r");
    wait_idle();

    base = timeout_pulses;
    send_str("L3");
    repeat (110) @(posedge clk);
`ifdef UART_CMD_TIMEOUT_EN
    check("timeout_pulses", timeout_pulses - base, 1);
    line_q.delete();
    send_str("R\r");
    wait_idle();
`else
    check("no_timeout_pulses", timeout_pulses - base, 0);
    send_str("F\r");
    wait_idle();
    check("led_after_slow_L3F", 32'(led_value), 32'h3F);
`endif

    ready_mode = 1;
    for (int i = 0; i < 40; i++) begin
      send_rand_cmd();
      wait_idle();
    end

    ready_mode = 2;
    send_str("R\r");
    wait_tx_valid();
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1;
    check("reset_mid_resp_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("reset_mid_resp_led", 32'(led_value), 32'd0);
    check("reset_mid_resp_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    exp_q.delete();
    line_q.delete();
    led_m = '0;
    ready_mode = 0;
    send_str("R\r");
    wait_idle();

    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
